// File: rtl/logs_nco_bank.sv
`default_nettype none
// ============================================================================
//  Module   : logs_nco_bank
//  Brief    : Time-multiplexed bank of C NCOs sharing one phase adder; emits
//             per-voice pulse waves and a registered active-voice count.
//             Optional LOGS_NCO_XORSHIFT_SEED_EN gives xorshift32 phase seeds.
//  Revision : 1.0 - initial release
// ============================================================================
module logs_nco_bank #(
    parameter int N  = 8,
    parameter int C  = 4,
    parameter int AW = (C > 1) ? $clog2(C) : 1,
    parameter int MW = $clog2(C + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    output logic [C-1:0]  snd,
    output logic [MW-1:0] mix,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_last = AW'(C - 1);
    localparam logic [N-1:0]  c_half = {1'b1, {(N-1){1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_nxt;
    logic [N-1:0]    r_phase [C];
    logic [N-2:0]    r_freq  [C];
    logic [N-1:0]    r_duty  [C];
    logic            w_addr_ok;
    logic [MW-1:0]   w_pop;

`ifdef LOGS_NCO_XORSHIFT_SEED_EN
    // Elaboration-time seed: xorshift32 iterated k times from a fixed start.
    function automatic logic [N-1:0] seed(input int k);
        logic [31:0] x;
        x = 32'hD1BD_81EB;
        for (int i = 0; i < k; i++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
        end
        return N'(x);
    endfunction
`endif

    if (C == (1 << AW)) begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
        assign w_addr_ok = (wr_addr <= c_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        busy        = 1'b0;
        overrun     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (step) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                busy    = 1'b1;
                overrun = step;
                if (r_idx == c_last) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Compare and accumulate use pre-update values, so a same-cycle write only
    // lands in the register and shows on the next visit to that channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snd <= '0;
            for (int k = 0; k < C; k++) begin
`ifdef LOGS_NCO_XORSHIFT_SEED_EN
                r_phase[k] <= seed(k);
`else
                r_phase[k] <= '0;
`endif
                r_freq[k]  <= '0;
                r_duty[k]  <= c_half;
            end
        end else begin
            if (r_state == ST_SWEEP) begin
                snd[r_idx]     <= (r_phase[r_idx] >= r_duty[r_idx]);
                r_phase[r_idx] <= r_phase[r_idx] + {1'b0, r_freq[r_idx]};
            end
            if (wr_en && w_addr_ok) begin
                if (wr_sel) begin
                    r_duty[wr_addr] <= wr_data;
                end else begin
                    r_freq[wr_addr] <= wr_data[N-2:0];
                end
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < C; k++) begin
            w_pop = w_pop + MW'(snd[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mix <= '0;
        end else begin
            mix <= w_pop;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logs_nco_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logs_nco_bank
//  Brief    : Scoreboard bench for logs_nco_bank (N=8, C=4), directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logs_nco_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] snd;
    logic [2:0] mix;
    logic       busy;
    logic       overrun;

    logs_nco_bank #(.N(8), .C(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .step    (step),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .snd     (snd),
        .mix     (mix),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] snd;
        logic [2:0] mix;
        logic [3:0] mask;
        bit         chk_mix;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a falling busy marks a completed sweep; mix is checked a cycle later.
    bit         prev_busy = 1'b0;
    bit         mix_pend  = 1'b0;
    logic [2:0] mix_exp   = '0;
    exp_t       cur;

    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            mix_pend  = 1'b0;
        end else begin
            if (mix_pend) begin
                check("mix", 32'(mix), 32'(mix_exp));
                mix_pend = 1'b0;
            end
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_sweep: got snd=%0h expected no sweep", snd);
                end else begin
                    cur = q.pop_front();
                    check("snd", 32'(snd & cur.mask), 32'(cur.snd & cur.mask));
                    if (cur.chk_mix) begin
                        mix_pend = 1'b1;
                        mix_exp  = cur.mix;
                    end
                end
            end
            prev_busy = busy;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic push(input logic [3:0] s, input logic [2:0] m, input logic [3:0] mask, input bit cm);
        exp_t e;
        e.snd = s;
        e.mix = m;
        e.mask = mask;
        e.chk_mix = cm;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: got busy=1 expected busy=0 within 20 cycles");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_sweep(input logic [3:0] s, input logic [2:0] m);
        push(s, m, 4'hF, 1'b1);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1);
    end

    initial begin
        int bc;
        int oc;

        // Reset state
        @(posedge clk);
        #1;
        do_reset();
        check("rst_snd", 32'(snd), 0);
        check("rst_mix", 32'(mix), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Basic square wave on channel 0
        wr(1'b0, 2'd0, 8'h40);
        do_sweep(4'b0000, 3'd0);
        do_sweep(4'b0000, 3'd0);
        do_sweep(4'b0001, 3'd1);
        do_sweep(4'b0001, 3'd1);

        // Phase wrap on channel 2: 00,7F,FE,7D then FC
        do_reset();
        wr(1'b0, 2'd2, 8'h7F);
        do_sweep(4'b0000, 3'd0);
        do_sweep(4'b0000, 3'd0);
        do_sweep(4'b0100, 3'd1);
        do_sweep(4'b0000, 3'd0);
        wr(1'b1, 2'd2, 8'hFC);
        do_sweep(4'b0100, 3'd1);

        // Duty threshold, then all voices high
        do_reset();
        wr(1'b1, 2'd1, 8'h20);
        wr(1'b0, 2'd1, 8'h10);
        do_sweep(4'b0000, 3'd0);
        do_sweep(4'b0000, 3'd0);
        do_sweep(4'b0010, 3'd1);
        for (int a = 0; a < 4; a++) wr(1'b1, 2'(a), 8'h00);
        do_sweep(4'b1111, 3'd4);

        // Step held two cycles: one sweep, busy 4 cycles, overrun 1 cycle
        do_reset();
        push(4'b0000, 3'd0, 4'hF, 1'b1);
        bc = 0;
        oc = 0;
        step = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bc += int'(busy);
            oc += int'(overrun);
            @(posedge clk);
            #1;
            step = (i == 0);
        end
        check("busy_cycles", 32'(bc), 4);
        check("overrun_cycles", 32'(oc), 1);
        repeat (2) @(posedge clk);
        #1;

        // Step during the last channel is dropped
        push(4'b0000, 3'd0, 4'hF, 1'b1);
        step = 1'b1;
        @(posedge clk); #1; step = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1; step = 1'b1;
        @(negedge clk);
        check("overrun_last", 32'(overrun), 1);
        @(posedge clk); #1; step = 1'b0;
        @(negedge clk);
        check("busy_after_drop", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;

        // Write collision: channel 1 accumulates the old frequency
        do_reset();
        wr(1'b0, 2'd1, 8'h10);
        wr(1'b1, 2'd1, 8'h10);
        push(4'b0000, 3'd0, 4'hF, 1'b1);
        step = 1'b1;
        @(posedge clk); #1; step = 1'b0;
        @(posedge clk); #1;
        wr(1'b0, 2'd1, 8'h01);
        wait_idle();
        do_sweep(4'b0010, 3'd1);

        // Asynchronous reset in the middle of a sweep
        step = 1'b1;
        @(posedge clk); #1; step = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        q.delete();
        #1;
        check("arst_snd", 32'(snd), 0);
        check("arst_mix", 32'(mix), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_overrun", 32'(overrun), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr(1'b1, 2'd1, 8'h01);
        do_sweep(4'b0000, 3'd0);

        // Initial phase seed
        do_reset();
`ifdef LOGS_NCO_XORSHIFT_SEED_EN
        push(4'b0001, 3'd0, 4'b0001, 1'b0);
        step = 1'b1;
        @(posedge clk); #1; step = 1'b0;
        wait_idle();
`else
        do_sweep(4'b0000, 3'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
